// File: rtl/receive.sv
// Instruction receiver: requests a burst from a transmitter, stores the acknowledged words
// in a local buffer, and reports completion, overflow and timeout.
module receive #(
    parameter int IWIDTH  = 32,
    parameter int DEPTH   = 16,
    parameter int AWIDTH  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_i_start,
    output logic              r_o_syn,
    input  logic [IWIDTH-1:0] r_i_instr,
    input  logic              r_i_last,
    input  logic              r_i_ack,
    input  logic [AWIDTH-1:0] r_i_raddr,
    output logic [IWIDTH-1:0] r_o_rdata,
    output logic [AWIDTH:0]   r_o_count,
    output logic              r_o_busy,
    output logic              r_o_done,
    output logic              r_o_ovf,
    output logic              r_o_err
);

    localparam int MEM_WORDS = 2 ** AWIDTH;
    localparam int IDW       = $clog2(TIMEOUT + 1);

    localparam logic [AWIDTH:0] DEPTH_W   = (AWIDTH + 1)'(DEPTH);
    localparam logic [IDW-1:0]  IDLE_LAST = IDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AWIDTH:0]    count_q, count_d;
    logic [IDW-1:0]     idle_q,  idle_d;
    logic               ovf_q,   ovf_d;
    logic               err_q,   err_d;
    logic               syn_q,   syn_d;
    logic               done_q,  done_d;
    logic               wr_en_s;
    logic [AWIDTH-1:0]  wr_addr_s;

    // Addressed by the full AWIDTH range; only entries below DEPTH are ever written.
    logic [IWIDTH-1:0]  mem_q [MEM_WORDS];

    assign wr_addr_s = count_q[AWIDTH-1:0];

    // Next-state and output decode for the load sequencer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idle_d  = idle_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        syn_d   = 1'b0;
        done_d  = 1'b0;
        wr_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (r_i_start) begin
                    state_d = ST_SYNC;
                    count_d = '0;
                    idle_d  = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    syn_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                syn_d = 1'b1;
                if (r_i_ack) begin
                    idle_d = '0;
                    if (count_q < DEPTH_W) begin
                        wr_en_s = 1'b1;
                        count_d = count_q + (AWIDTH + 1)'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (r_i_last) begin
                        state_d = ST_DONE;
                        syn_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end else if (idle_q >= IDLE_LAST) begin
                    // Transmitter went quiet: abandon the load but keep what was stored.
                    state_d = ST_IDLE;
                    idle_d  = '0;
                    err_d   = 1'b1;
                    syn_d   = 1'b0;
                end else begin
                    idle_d = idle_q + IDW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idle_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            syn_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idle_q  <= idle_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            syn_q   <= syn_d;
            done_q  <= done_d;
        end
    end

    // Buffer write port; contents deliberately survive reset.
    always_ff @(posedge r_clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= r_i_instr;
        end
    end

    assign r_o_rdata = mem_q[r_i_raddr];
    assign r_o_syn   = syn_q;
    assign r_o_busy  = syn_q;
    assign r_o_done  = done_q;
    assign r_o_count = count_q;
    assign r_o_ovf   = ovf_q;
    assign r_o_err   = err_q;

endmodule

// File: tb/tb_receive.sv
// Randomized bench for receive: a transfer-level model predicts stored words, count,
// overflow, timeout and the done pulse for each load.
module tb_receive;

    localparam int IW      = 32;
    localparam int DEPTH   = 4;
    localparam int AW      = 3;
    localparam int TIMEOUT = 8;

    logic          r_clk = 1'b0;
    logic          r_rst = 1'b0;
    logic          r_i_start = 1'b0;
    logic          r_o_syn;
    logic [IW-1:0] r_i_instr = '0;
    logic          r_i_last = 1'b0;
    logic          r_i_ack = 1'b0;
    logic [AW-1:0] r_i_raddr = '0;
    logic [IW-1:0] r_o_rdata;
    logic [AW:0]   r_o_count;
    logic          r_o_busy;
    logic          r_o_done;
    logic          r_o_ovf;
    logic          r_o_err;

    receive #(.IWIDTH(IW), .DEPTH(DEPTH), .AWIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
        .r_clk(r_clk), .r_rst(r_rst), .r_i_start(r_i_start), .r_o_syn(r_o_syn),
        .r_i_instr(r_i_instr), .r_i_last(r_i_last), .r_i_ack(r_i_ack),
        .r_i_raddr(r_i_raddr), .r_o_rdata(r_o_rdata), .r_o_count(r_o_count),
        .r_o_busy(r_o_busy), .r_o_done(r_o_done), .r_o_ovf(r_o_ovf), .r_o_err(r_o_err)
    );

    always #5 r_clk = ~r_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    // Model state: buffer image plus the outcome of the load in progress.
    logic [IW-1:0] m_mem [DEPTH];
    bit            m_vld [DEPTH] = '{default: 1'b0};
    int            m_count;
    bit            m_ovf;
    logic [IW-1:0] word_q [$];
    int            gap_q  [$];

    // Done pulses observed mid-cycle.
    always @(negedge r_clk) if (r_o_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic idle_noise(input string tag, input int cycles);
        int d0 = done_cnt;
        for (int i = 0; i < cycles; i++) begin
            r_i_ack   = 1'($urandom_range(0, 1));
            r_i_last  = 1'($urandom_range(0, 1));
            r_i_instr = $urandom;
            tick();
        end
        r_i_ack = 1'b0; r_i_last = 1'b0;
        check({tag, ":idle_count"}, 64'(r_o_count), 64'(m_count));
        check({tag, ":idle_syn"}, 64'(r_o_syn), 64'd0);
        check({tag, ":idle_done"}, 64'(done_cnt - d0), 64'd0);
    endtask

    // One acknowledged word; checks write-through timing on the target address.
    task automatic beat(input string tag, input logic [IW-1:0] w, input bit last);
        r_i_start = 1'($urandom_range(0, 1));
        r_i_ack   = 1'b1;
        r_i_instr = w;
        r_i_last  = last;
        if (m_count < DEPTH) begin
            r_i_raddr = AW'(m_count);
            #1;
            if (m_vld[m_count]) check({tag, ":old_rdata"}, 64'(r_o_rdata), 64'(m_mem[m_count]));
            tick();
            check({tag, ":new_rdata"}, 64'(r_o_rdata), 64'(w));
            m_mem[m_count] = w;
            m_vld[m_count] = 1'b1;
            m_count++;
        end else begin
            m_ovf = 1'b1;
            tick();
        end
        r_i_ack = 1'b0; r_i_last = 1'b0; r_i_start = 1'b0;
    endtask

    task automatic start_load(input string tag);
        r_i_start = 1'b1;
        tick();
        r_i_start = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
        check({tag, ":syn_on"}, 64'(r_o_syn), 64'd1);
        check({tag, ":busy_on"}, 64'(r_o_busy), 64'd1);
        check({tag, ":cnt_clr"}, 64'(r_o_count), 64'd0);
        check({tag, ":flags_clr"}, {62'd0, r_o_ovf, r_o_err}, 64'd0);
    endtask

    task automatic readback(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            if (m_vld[a]) begin
                r_i_raddr = AW'(a);
                #1;
                check($sformatf("%s:mem%0d", tag, a), 64'(r_o_rdata), 64'(m_mem[a]));
            end
        end
    endtask

    // Plays word_q/gap_q as one load; a gap of TIMEOUT or more means the transmitter stalls.
    task automatic do_xfer(input string tag);
        int  n   = word_q.size();
        int  d0;
        bit  tmo = 1'b0;
        start_load(tag);
        d0 = done_cnt;
        for (int i = 0; i < n; i++) begin
            if (gap_q[i] >= TIMEOUT) begin
                for (int g = 0; g < TIMEOUT - 1; g++) begin
                    r_i_start = 1'($urandom_range(0, 1));
                    r_i_last  = 1'($urandom_range(0, 1));
                    tick();
                end
                check({tag, ":syn_pre_tmo"}, 64'(r_o_syn), 64'd1);
                r_i_start = 1'b0; r_i_last = 1'b0;
                tick();
                tmo = 1'b1;
                break;
            end
            for (int g = 0; g < gap_q[i]; g++) begin
                r_i_start = 1'($urandom_range(0, 1));
                r_i_last  = 1'($urandom_range(0, 1));
                tick();
            end
            beat(tag, word_q[i], i == n - 1);
        end
        check({tag, ":syn_end"}, 64'(r_o_syn), 64'd0);
        check({tag, ":busy_end"}, 64'(r_o_busy), 64'd0);
        check({tag, ":count"}, 64'(r_o_count), 64'(m_count));
        check({tag, ":ovf"}, 64'(r_o_ovf), 64'(m_ovf));
        check({tag, ":err"}, 64'(r_o_err), 64'(tmo));
        if (!tmo) begin
            check({tag, ":done_hi"}, 64'(r_o_done), 64'd1);
            r_i_start = 1'($urandom_range(0, 1));
            tick();
            r_i_start = 1'b0;
            check({tag, ":done_lo"}, 64'(r_o_done), 64'd0);
            check({tag, ":idle_after"}, 64'(r_o_syn), 64'd0);
        end
        check({tag, ":done_pulses"}, 64'(done_cnt - d0), 64'(!tmo));
        readback(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        m_count = 0;
        m_ovf   = 1'b0;
        tick(); tick();
        check("rst:syn", 64'(r_o_syn), 64'd0);
        check("rst:busy", 64'(r_o_busy), 64'd0);
        check("rst:done", 64'(r_o_done), 64'd0);
        check("rst:count", 64'(r_o_count), 64'd0);
        check("rst:ovf", 64'(r_o_ovf), 64'd0);
        check("rst:err", 64'(r_o_err), 64'd0);
        r_rst = 1'b1;
        idle_noise("rst", 4);

        word_q = '{32'h2002_0005};                              gap_q = '{0};
        do_xfer("one");
        word_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333}; gap_q = '{0, 2, 2};
        do_xfer("three");
        word_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5}; gap_q = '{0, 0, 1, 0, 0, 0};
        do_xfer("ovf");
        idle_noise("ovf", 3);
        check("ovf:sticky", 64'(r_o_ovf), 64'd1);
        word_q = '{32'hBEEF_0001, 32'hBEEF_0002};                gap_q = '{0, TIMEOUT};
        do_xfer("tmo");
        idle_noise("tmo", 3);
        check("tmo:sticky", 64'(r_o_err), 64'd1);

        // Asynchronous reset part way through a three-word load.
        start_load("arst");
        beat("arst", 32'hC0DE_0001, 1'b0);
        beat("arst", 32'hC0DE_0002, 1'b0);
        #2 r_rst = 1'b0;
        #1;
        m_count = 0;
        check("arst:syn", 64'(r_o_syn), 64'd0);
        check("arst:busy", 64'(r_o_busy), 64'd0);
        check("arst:count", 64'(r_o_count), 64'd0);
        tick(); tick();
        r_rst = 1'b1;
        word_q = '{32'hD00D_0001, 32'hD00D_0002}; gap_q = '{1, 0};
        do_xfer("post_rst");

        for (int t = 0; t < 40; t++) begin
            int n = $urandom_range(1, 6);
            word_q.delete(); gap_q.delete();
            for (int i = 0; i < n; i++) begin
                int r = $urandom_range(0, 11);
                word_q.push_back($urandom);
                gap_q.push_back(r == 0 ? TIMEOUT : (r < 5 ? $urandom_range(1, TIMEOUT - 1) : 0));
            end
            do_xfer($sformatf("rnd%0d", t));
            if (t % 5 == 0) idle_noise($sformatf("rnd%0d", t), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
